// File: rtl/nbit_adder.sv
// Registered N-bit unsigned adder: an explicit ripple chain of full-adder
// cells feeding output registers, with a carry-out flag and a valid strobe.

module nbit_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module nbit_adder #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] out,
  output logic         carry,
  output logic         out_valid
);
  // Handshake: in_valid=1 at an edge captures A+B; out_valid is high for
  // exactly the following cycle. There is no ready: the consumer must take it.

  logic [N:0]   c;
  logic [N-1:0] s;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_chain
    nbit_adder_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Result registers hold their value while idle; only the strobe drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out   <= s;
        carry <= c[N];
      end
    end
  end

endmodule

// File: tb/tb_nbit_adder.sv
// Bench for nbit_adder: directed vector table and reset sequences on N=32,
// then randomized traffic on N=32, N=8 and N=1 against an arithmetic model.

module tb_nbit_adder;

  logic clk;
  logic rst_n;

  logic        v32, c32, ov32;
  logic [31:0] a32, b32, o32;
  logic        v8, c8, ov8;
  logic [7:0]  a8, b8, o8;
  logic        v1, c1, ov1;
  logic [0:0]  a1, b1, o1;

  int total = 0;
  int bad   = 0;

  nbit_adder #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .A(a32), .B(b32),
    .out(o32), .carry(c32), .out_valid(ov32)
  );
  nbit_adder #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8),
    .out(o8), .carry(c8), .out_valid(ov8)
  );
  nbit_adder #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1),
    .out(o1), .carry(c1), .out_valid(ov1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_carry;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] eo, input logic ec, input logic ev);
    check({name, " out"},       64'(o32),  64'(eo));
    check({name, " carry"},     64'(c32),  64'(ec));
    check({name, " out_valid"}, 64'(ov32), 64'(ev));
  endtask

  task automatic drive32(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b);
    rst_n = r;
    v32   = v;
    a32   = a;
    b32   = b;
  endtask

  // scoreboard state for the randomized phase
  logic [32:0] exp_q32[$];
  logic [8:0]  exp_q8[$];
  logic [1:0]  exp_q1[$];
  logic [32:0] held32;
  logic [8:0]  held8;
  logic [1:0]  held1;

  initial begin
    vecs[0]  = '{"add 10+20",      1'b1, 1'b1, 32'd10,         32'd20,         32'd30,         1'b0, 1'b1};
    vecs[1]  = '{"add 100+200",    1'b1, 1'b1, 32'd100,        32'd200,        32'd300,        1'b0, 1'b1};
    vecs[2]  = '{"add 1291+21412", 1'b1, 1'b1, 32'd1291,       32'd21412,      32'd22703,      1'b0, 1'b1};
    vecs[3]  = '{"add 69+69",      1'b1, 1'b1, 32'd69,         32'd69,         32'd138,        1'b0, 1'b1};
    vecs[4]  = '{"wrap max+1",     1'b1, 1'b1, 32'hFFFF_FFFF,  32'h1,          32'h0,          1'b1, 1'b1};
    vecs[5]  = '{"hold carry",     1'b1, 1'b0, 32'h1234_5678,  32'h9ABC_DEF0,  32'h0,          1'b1, 1'b0};
    vecs[6]  = '{"wrap max+max",   1'b1, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b1, 1'b1};
    vecs[7]  = '{"wrap msb+msb",   1'b1, 1'b1, 32'h8000_0000,  32'h8000_0000,  32'h0,          1'b1, 1'b1};
    vecs[8]  = '{"add 5+7",        1'b1, 1'b1, 32'd5,          32'd7,          32'd12,         1'b0, 1'b1};
    vecs[9]  = '{"hold 12 a",      1'b1, 1'b0, 32'hDEAD_BEEF,  32'hCAFE_F00D,  32'd12,         1'b0, 1'b0};
    vecs[10] = '{"hold 12 b",      1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd12,         1'b0, 1'b0};
    vecs[11] = '{"add 0+0",        1'b1, 1'b1, 32'd0,          32'd0,          32'd0,          1'b0, 1'b1};

    rst_n = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0;
    v8  = 1'b0; a8  = '0; b8  = '0;
    v1  = 1'b0; a1  = '0; b1  = '0;

    tick();
    tick();
    check32("reset", 32'd0, 1'b0, 1'b0);
    check("reset out_valid n8", 64'(ov8), 64'd0);
    check("reset out_valid n1", 64'(ov1), 64'd0);

    // directed table, one edge per record
    for (int i = 0; i < 12; i++) begin
      drive32(vecs[i].rst_n, vecs[i].in_valid, vecs[i].a, vecs[i].b);
      tick();
      check32(vecs[i].name, vecs[i].exp_out, vecs[i].exp_carry, vecs[i].exp_valid);
    end

    // leave a nonzero result, then reset held for two edges with valid input
    drive32(1'b1, 1'b1, 32'd40, 32'd2);
    tick();
    check32("pre-reset 42", 32'd42, 1'b0, 1'b1);
    drive32(1'b0, 1'b1, 32'd3, 32'd4);
    tick();
    check32("reset edge 1", 32'd0, 1'b0, 1'b0);
    tick();
    check32("reset edge 2", 32'd0, 1'b0, 1'b0);
    drive32(1'b1, 1'b1, 32'd3, 32'd4);
    tick();
    check32("after release 3+4", 32'd7, 1'b0, 1'b1);

    // reset on the same edge as a carrying operation discards it
    drive32(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
    tick();
    check32("reset drops op", 32'd0, 1'b0, 1'b0);
    drive32(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2);
    tick();
    check32("no late result", 32'd0, 1'b0, 1'b0);

    // randomized phase on all three widths
    held32 = '0;
    held8  = '0;
    held1  = '0;
    for (int n = 0; n < 1000; n++) begin
      rst_n = 1'b1;
      v32 = 1'($urandom_range(0, 1)); a32 = $urandom; b32 = $urandom;
      v8  = 1'($urandom_range(0, 1)); a8  = 8'($urandom); b8 = 8'($urandom);
      v1  = 1'($urandom_range(0, 1)); a1  = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
      if (v32) exp_q32.push_back(33'(a32) + 33'(b32));
      if (v8)  exp_q8.push_back(9'(a8) + 9'(b8));
      if (v1)  exp_q1.push_back(2'(a1) + 2'(b1));
      tick();

      check("rand n32 out_valid", 64'(ov32), 64'(v32));
      if (v32 && exp_q32.size() > 0) held32 = exp_q32.pop_front();
      check("rand n32 sum", 64'({c32, o32}), 64'(held32));

      check("rand n8 out_valid", 64'(ov8), 64'(v8));
      if (v8 && exp_q8.size() > 0) held8 = exp_q8.pop_front();
      check("rand n8 sum", 64'({c8, o8}), 64'(held8));

      check("rand n1 out_valid", 64'(ov1), 64'(v1));
      if (v1 && exp_q1.size() > 0) held1 = exp_q1.pop_front();
      check("rand n1 sum", 64'({c1, o1}), 64'(held1));
    end
    check("queue n32 drained", 64'(exp_q32.size()), 64'd0);
    check("queue n8 drained",  64'(exp_q8.size()),  64'd0);
    check("queue n1 drained",  64'(exp_q1.size()),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
